// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : fetch_pkg                                                        |
// | Shared types and constants for the instruction fetch front end: FSM state  |
// | encoding, datapath widths, the decode-side NOP, the fetch buffer entry     |
// | layout and the fetch-address legality check.                               |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package fetch_pkg;

    localparam int          c_xlen        = 32;
    localparam int          c_instr_bytes = 4;
    // Canonical NOP (addi x0,x0,0) that decode substitutes on a flush.
    localparam logic [31:0] c_nop_instr   = 32'h0000_0013;

    // Fetch FSM encoding.
    localparam int          c_state_w = 2;
    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_run   = 2'd1;
    localparam logic [1:0]  c_st_fault = 2'd2;

    // One fetch buffer slot: byte address plus the instruction word read there.
    typedef struct packed {
        logic [c_xlen-1:0] pc;
        logic [c_xlen-1:0] instr;
    } fetch_entry_t;

    // An address may be fetched only if it is word aligned and its word index
    // lies inside the instruction memory.
    function automatic logic addr_legal(input logic [31:0] addr,
                                        input logic [31:0] depth);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fetch_buffer                                                     |
// | Two-entry FIFO of {pc, instr} between fetch and decode.                    |
// |   i_push / i_entry : enqueue an entry (accepted when not full, or when a   |
// |                      pop happens in the same cycle)                         |
// |   i_pop            : dequeue the head (ignored when empty)                 |
// |   i_flush          : discard all entries; has priority over push and pop   |
// |   o_head           : head entry, all zeros when empty                      |
// |   o_count / o_full / o_empty : occupancy                                   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_entry,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count,
    output logic         o_full,
    output logic         o_empty
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == 2'd2);
    assign w_empty   = (r_count == 2'd0);
    assign w_do_pop  = i_pop && !w_empty && !i_flush;
    // A full buffer can still take a push when the head leaves in the same cycle.
    assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : instruction_fetch_unit                                           |
// | Owns the PC, reads the combinational instruction memory and queues         |
// | {pc, instr} in a 2-entry buffer delivered to decode over valid/ready.      |
// | Redirects flush the buffer and restart fetch; illegal addresses latch a    |
// | fault until the next legal redirect.                                       |
// |   clk, reset (sync, active high), start                                    |
// |   imem_addr -> / imem_instr <-           instruction memory                |
// |   redirect_valid, redirect_target        from execute                      |
// |   out_valid, out_ready, out_instr, out_pc  decode handshake                |
// |   fault, fault_addr                        latched fetch fault             |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam logic [31:0] c_depth = 32'(IMEM_DEPTH);

    logic [c_state_w-1:0] r_state;
    logic [31:0]          r_pc;
    logic                 r_fault;
    logic [31:0]          r_fault_addr;

    logic         w_redirect;
    logic         w_pc_legal;
    logic         w_target_legal;
    logic         w_pop;
    logic         w_push;
    fetch_entry_t w_entry;
    fetch_entry_t w_head;
    logic [1:0]   w_count;
    logic         w_full;
    logic         w_empty;
    logic         w_unused_count;

    // Redirects only mean something once fetching has been started.
    assign w_redirect     = redirect_valid && (r_state != c_st_idle);
    assign w_pc_legal     = addr_legal(r_pc, c_depth);
    assign w_target_legal = addr_legal(redirect_target, c_depth);

    assign w_pop   = !w_empty && out_ready;
    assign w_push  = (r_state == c_st_run) && !w_redirect && w_pc_legal &&
                     (!w_full || w_pop);
    assign w_entry = '{pc: r_pc, instr: imem_instr};

    fetch_buffer u_buffer (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .i_entry (w_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_pc         <= RESET_PC;
            r_fault      <= 1'b0;
            r_fault_addr <= 32'h0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= c_st_run;
                    end
                end
                c_st_run, c_st_fault: begin
                    if (w_redirect) begin
                        if (w_target_legal) begin
                            r_pc         <= redirect_target;
                            r_state      <= c_st_run;
                            r_fault      <= 1'b0;
                            r_fault_addr <= 32'h0;
                        end else begin
                            // pc is left alone; only a legal redirect resumes.
                            r_state      <= c_st_fault;
                            r_fault      <= 1'b1;
                            r_fault_addr <= redirect_target;
                        end
                    end else if (r_state == c_st_run) begin
                        if (w_push) begin
                            r_pc <= r_pc + 32'(c_instr_bytes);
                        end else if (!w_pc_legal) begin
                            // Ran off the end of memory; buffered entries still drain.
                            r_state      <= c_st_fault;
                            r_fault      <= 1'b1;
                            r_fault_addr <= r_pc;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign imem_addr      = r_pc;
    assign out_valid      = !w_empty;
    assign out_instr      = w_head.instr;
    assign out_pc         = w_head.pc;
    assign fault          = r_fault;
    assign fault_addr     = r_fault_addr;
    assign w_unused_count = ^w_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_instruction_fetch_unit                                        |
// | Directed self-checking bench for instruction_fetch_unit with a 256-word    |
// | combinational instruction memory model.                                    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_addr;

    logic [31:0] r_mem [0:255];

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (256)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .fault           (fault),
        .fault_addr      (fault_addr)
    );

    assign imem_instr = r_mem[imem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) r_mem[i] = 32'h1000_0000 + 32'(i);
        r_mem[0] = 32'h0020_81B3;
        r_mem[1] = 32'h4041_84B3;

        reset = 1'b1; start = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; out_ready = 1'b1;
        #1;
        do_reset();

        // ---- Reset state ----
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc",    imem_addr, 32'h0);
        check("rst_opc",   out_pc, 32'h0);
        check("rst_oins",  out_instr, 32'h0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_faddr", fault_addr, 32'h0);

        // ---- 1: start latency and streaming ----
        start = 1'b1;
        tick();                         // N+1
        start = 1'b0;
        check("t1_n1_valid", 32'(out_valid), 32'd0);
        tick();                         // N+2
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_pc0",   out_pc, 32'h0);
        check("t1_ins0",  out_instr, 32'h0020_81B3);
        tick();
        check("t1_pc4",   out_pc, 32'h4);
        check("t1_ins4",  out_instr, 32'h4041_84B3);
        tick();
        check("t1_pc8",   out_pc, 32'h8);
        check("t1_ins8",  out_instr, 32'h1000_0002);

        // ---- 2: back-pressure ----
        do_reset();
        start = 1'b1;
        tick();                         // N+1
        start = 1'b0;
        out_ready = 1'b0;
        tick();                         // N+2
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 32'(out_valid), 32'd1);
            check("t2_hold_pc",    out_pc, 32'h0);
            check("t2_hold_ins",   out_instr, 32'h0020_81B3);
            tick();
        end
        check("t2_pc_stop", imem_addr, 32'h8);
        out_ready = 1'b1;
        check("t2_rel_pc0", out_pc, 32'h0);
        tick();
        check("t2_rel_pc4", out_pc, 32'h4);
        tick();
        check("t2_rel_pc8", out_pc, 32'h8);
        check("t2_rel_valid", 32'(out_valid), 32'd1);
        tick();
        check("t2_rel_pc12", out_pc, 32'hC);

        // ---- 3: redirect flushes a full buffer ----
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0020;
        tick();
        redirect_valid = 1'b0;
        check("t3_flushed", 32'(out_valid), 32'd0);
        tick();
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_pc",    out_pc, 32'h20);
        check("t3_ins",   out_instr, 32'h1000_0008);

        // ---- 4: misaligned redirect faults, legal redirect recovers ----
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0022;
        tick();
        redirect_valid = 1'b0;
        check("t4_fault",  32'(fault), 32'd1);
        check("t4_faddr",  fault_addr, 32'h22);
        check("t4_pc_keep", imem_addr, 32'h24);
        tick();
        tick();
        check("t4_no_push", 32'(out_valid), 32'd0);
        check("t4_fault_hold", 32'(fault), 32'd1);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0;
        tick();
        redirect_valid = 1'b0;
        check("t4_clear", 32'(fault), 32'd0);
        check("t4_faddr0", fault_addr, 32'h0);
        tick();
        check("t4_valid", 32'(out_valid), 32'd1);
        check("t4_pc0",   out_pc, 32'h0);

        // ---- 5: last word then sequential overrun ----
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_03FC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("t5_valid", 32'(out_valid), 32'd1);
        check("t5_pc",    out_pc, 32'h3FC);
        check("t5_ins",   out_instr, 32'h1000_00FF);
        check("t5_nofault_yet", 32'(fault), 32'd0);
        tick();
        check("t5_fault", 32'(fault), 32'd1);
        check("t5_faddr", fault_addr, 32'h400);
        check("t5_drained", 32'(out_valid), 32'd0);

        // ---- 6: reset while running with a full buffer ----
        out_ready       = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        check("t6_full_pc", imem_addr, 32'h8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_fault", 32'(fault), 32'd0);
        check("t6_pc",    imem_addr, 32'h0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h20;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        check("t6_idle_valid", 32'(out_valid), 32'd0);
        check("t6_idle_pc",    imem_addr, 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t6_restart_valid", 32'(out_valid), 32'd1);
        check("t6_restart_pc",    out_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
